// File: rtl/servo_ramp_controller_if.sv
// Command port for servo_ramp_controller.
// One valid/ready transfer writes the target duty of one servo channel.
// The master drives valid/channel/duty; the slave (the controller) drives ready.
interface servo_ramp_controller_if #(
  parameter int CH_W   = 1,
  parameter int DUTY_W = 10
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [CH_W-1:0]   cmd_ch;
  logic [DUTY_W-1:0] cmd_duty;

  modport master (
    output cmd_valid,
    output cmd_ch,
    output cmd_duty,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_ch,
    input  cmd_duty,
    output cmd_ready
  );
endinterface

// File: rtl/servo_ramp_controller.sv
// servo_ramp_controller: multi-channel hobby-servo PWM generator.
// A prescaler (pre_cnt) and a unit counter (unit_cnt) define one frame of
// PERIOD_UNITS duty units. Each channel's applied duty (cur) moves toward
// its commanded target (tgt) by at most STEP units, and only on the last
// cycle of a frame, so every pulse is emitted with a single consistent duty.
// Commands are refused on that last cycle so a target write never collides
// with a ramp update.
// Optional feature macro: SERVO_NEUTRAL_TIMEOUT_EN. When defined, all
// targets fall back to NEUTRAL_DUTY after TIMEOUT_FRAMES frames without an
// accepted command.
module servo_ramp_controller #(
  parameter int NUM_CH       = 2,
  parameter int CH_W         = 1,
  parameter int DUTY_W       = 10,
  parameter int UNIT_CYCLES  = 1000,
  parameter int PERIOD_UNITS = 1000,
  parameter int NEUTRAL_DUTY = 75,
  parameter int MIN_DUTY     = 50,
  parameter int MAX_DUTY     = 100,
  parameter int STEP         = 4
`ifdef SERVO_NEUTRAL_TIMEOUT_EN
  ,
  parameter int TIMEOUT_FRAMES = 50
`endif
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  servo_ramp_controller_if.slave cmd,
  output logic [NUM_CH-1:0]      servo_pwm,
  output logic                   frame_tick,
  output logic                   busy
);

  localparam int PRE_W  = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int UNIT_W = (PERIOD_UNITS > 1) ? $clog2(PERIOD_UNITS) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(UNIT_CYCLES - 1);
  localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(PERIOD_UNITS - 1);

  localparam logic [DUTY_W-1:0] NEUTRAL_D = DUTY_W'(NEUTRAL_DUTY);
  localparam logic [DUTY_W-1:0] MIN_D     = DUTY_W'(MIN_DUTY);
  localparam logic [DUTY_W-1:0] MAX_D     = DUTY_W'(MAX_DUTY);
  localparam logic [DUTY_W-1:0] STEP_D    = DUTY_W'(STEP);
  localparam logic [31:0]       STEP_U    = 32'(STEP);

  logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic [UNIT_W-1:0] unit_cnt_q, unit_cnt_d;

  logic [NUM_CH-1:0][DUTY_W-1:0] tgt_q, tgt_d;
  logic [NUM_CH-1:0][DUTY_W-1:0] cur_q, cur_d;

  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic              frame_tick_q, frame_tick_d;
  logic              busy_q, busy_d;

  logic fe;
  logic accept;
  logic timeout_hit;

  // Commanded duty is limited to the servo's safe mechanical range.
  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] d_val);
    logic [DUTY_W-1:0] res;
    res = d_val;
    if (d_val < MIN_D) begin
      res = MIN_D;
    end else if (d_val > MAX_D) begin
      res = MAX_D;
    end
    return res;
  endfunction

  // One ramp step toward the target. The gap is always formed as
  // larger-minus-smaller, and landing exactly on the target when the gap is
  // within STEP means the result can never overshoot or wrap.
  function automatic logic [DUTY_W-1:0] ramp_step(input logic [DUTY_W-1:0] c_val,
                                                  input logic [DUTY_W-1:0] t_val);
    logic [DUTY_W-1:0] gap;
    logic [DUTY_W-1:0] res;
    res = c_val;
    gap = '0;
    if (c_val < t_val) begin
      gap = t_val - c_val;
      res = (32'(gap) > STEP_U) ? (c_val + STEP_D) : t_val;
    end else if (c_val > t_val) begin
      gap = c_val - t_val;
      res = (32'(gap) > STEP_U) ? (c_val - STEP_D) : t_val;
    end
    return res;
  endfunction

  // Frame end only exists while pulses are being generated, so a disabled
  // block neither ramps nor refuses commands.
  assign fe = enable && (pre_cnt_q == PRE_LAST) && (unit_cnt_q == UNIT_LAST);

  assign cmd.cmd_ready = reset_n && !fe;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  // Prescaler and unit counter; forced to zero while disabled so the first
  // enabled cycle starts a fresh frame at unit 0.
  always_comb begin
    pre_cnt_d  = pre_cnt_q;
    unit_cnt_d = unit_cnt_q;
    if (!enable) begin
      pre_cnt_d  = '0;
      unit_cnt_d = '0;
    end else if (pre_cnt_q == PRE_LAST) begin
      pre_cnt_d = '0;
      if (unit_cnt_q == UNIT_LAST) begin
        unit_cnt_d = '0;
      end else begin
        unit_cnt_d = unit_cnt_q + UNIT_W'(1);
      end
    end else begin
      pre_cnt_d = pre_cnt_q + PRE_W'(1);
    end
  end

`ifdef SERVO_NEUTRAL_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_FRAMES > 0) ? $clog2(TIMEOUT_FRAMES + 1) : 1;
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_FRAMES);
  localparam logic [TO_W-1:0] TO_PRE   = TO_W'(TIMEOUT_FRAMES - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Frames since the last accepted command; saturates at the limit and fires
  // the neutral fallback only on the frame end that reaches it.
  always_comb begin
    to_cnt_d    = to_cnt_q;
    timeout_hit = 1'b0;
    if (accept) begin
      to_cnt_d = '0;
    end else if (fe && (to_cnt_q != TO_LIMIT)) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
      if (to_cnt_q == TO_PRE) begin
        timeout_hit = 1'b1;
      end
    end
  end

  // Timeout frame counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Target writes from the command port and per-frame ramping of the applied
  // duty; channel numbers with no matching channel are simply dropped.
  always_comb begin
    tgt_d = tgt_q;
    cur_d = cur_q;
    if (fe) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cur_d[i] = ramp_step(cur_q[i], tgt_q[i]);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (accept && (cmd.cmd_ch == CH_W'(i))) begin
        tgt_d[i] = clamp_duty(cmd.cmd_duty);
      end
    end
    if (timeout_hit) begin
      tgt_d = {NUM_CH{NEUTRAL_D}};
    end
  end

  // Pulse outputs, frame tick and busy flag, all computed for registering.
  always_comb begin
    pwm_d        = '0;
    busy_d       = 1'b0;
    frame_tick_d = fe;
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_d[i] = enable && (32'(unit_cnt_q) < 32'(cur_q[i]));
      if (cur_d[i] != tgt_d[i]) begin
        busy_d = 1'b1;
      end
    end
  end

  // State register with synchronous active-low reset to neutral duty.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre_cnt_q    <= '0;
      unit_cnt_q   <= '0;
      tgt_q        <= {NUM_CH{NEUTRAL_D}};
      cur_q        <= {NUM_CH{NEUTRAL_D}};
      pwm_q        <= '0;
      frame_tick_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      pre_cnt_q    <= pre_cnt_d;
      unit_cnt_q   <= unit_cnt_d;
      tgt_q        <= tgt_d;
      cur_q        <= cur_d;
      pwm_q        <= pwm_d;
      frame_tick_q <= frame_tick_d;
      busy_q       <= busy_d;
    end
  end

  assign servo_pwm  = pwm_q;
  assign frame_tick = frame_tick_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_servo_ramp_controller.sv
// Testbench for servo_ramp_controller.
// Small frame (4 cycles/unit, 20 units/frame, 80-cycle frame), neutral 10,
// clamp 2..18, step 2, two channels with a 2-bit channel field.
// Stimulus pushes the expected per-frame high times and busy flag; a monitor
// measures each frame window between frame_tick pulses and pops/compares.
module tb_servo_ramp_controller;

  localparam int NUM_CH = 2;
  localparam int CH_W   = 2;
  localparam int DUTY_W = 10;

  typedef struct {
    int hi0;
    int hi1;
    int busy_v;
    int id;
  } frame_exp_t;

  logic              clk;
  logic              reset_n;
  logic              enable;
  logic [NUM_CH-1:0] servo_pwm;
  logic              frame_tick;
  logic              busy;

  int         checks;
  int         errors;
  int         frame_id;
  int         hi0;
  int         hi1;
  frame_exp_t exp_q[$];

  servo_ramp_controller_if #(.CH_W(CH_W), .DUTY_W(DUTY_W)) cmd_if ();

  servo_ramp_controller #(
    .NUM_CH      (NUM_CH),
    .CH_W        (CH_W),
    .DUTY_W      (DUTY_W),
    .UNIT_CYCLES (4),
    .PERIOD_UNITS(20),
    .NEUTRAL_DUTY(10),
    .MIN_DUTY    (2),
    .MAX_DUTY    (18),
    .STEP        (2)
`ifdef SERVO_NEUTRAL_TIMEOUT_EN
    ,
    .TIMEOUT_FRAMES(3)
`endif
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .cmd       (cmd_if),
    .servo_pwm (servo_pwm),
    .frame_tick(frame_tick),
    .busy      (busy)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushExp(input int h0, input int h1, input int b);
    frame_exp_t e;
    e.hi0    = h0;
    e.hi1    = h1;
    e.busy_v = b;
    e.id     = frame_id;
    frame_id++;
    exp_q.push_back(e);
  endtask

  task automatic waitTick(output int n);
    bit seen;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (frame_tick) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL tick_wait: got no frame_tick, expected one within 200 cycles");
      exp_q.delete();
    end
  endtask

  task automatic expectFrame(input int h0, input int h1, input int b);
    int n;
    pushExp(h0, h1, b);
    waitTick(n);
  endtask

  // Drives one command and holds it until the handshake completes; returns
  // the number of cycles it was refused.
  task automatic applyStimulus(input int ch, input int duty, output int waits);
    bit took;
    bit rdy;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_ch    = CH_W'(ch);
    cmd_if.cmd_duty  = DUTY_W'(duty);
    waits = 0;
    took  = 1'b0;
    while (!took && waits < 20) begin
      @(negedge clk);
      rdy = cmd_if.cmd_ready;
      @(posedge clk);
      #1;
      if (rdy) took = 1'b1;
      else waits++;
    end
    cmd_if.cmd_valid = 1'b0;
    if (!took) begin
      checks++;
      errors++;
      $display("[TB] FAIL cmd_accept: got no handshake, expected accept for ch %0d", ch);
    end
  endtask

  // Monitor: accumulates high cycles per channel over one frame window and
  // compares against the next queued expectation at each frame_tick.
  initial begin
    frame_exp_t e;
    hi0 = 0;
    hi1 = 0;
    forever begin
      @(negedge clk);
      if (!reset_n || !enable) begin
        hi0 = 0;
        hi1 = 0;
      end else begin
        hi0 = hi0 + (servo_pwm[0] ? 1 : 0);
        hi1 = hi1 + (servo_pwm[1] ? 1 : 0);
        if (frame_tick) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput($sformatf("frame%0d_ch0_high", e.id), hi0, e.hi0);
            checkOutput($sformatf("frame%0d_ch1_high", e.id), hi1, e.hi1);
            checkOutput($sformatf("frame%0d_busy", e.id), int'(busy), e.busy_v);
          end
          hi0 = 0;
          hi1 = 0;
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    int n;
    int w;
    checks   = 0;
    errors   = 0;
    frame_id = 0;
    reset_n  = 1'b0;
    enable   = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_ch    = '0;
    cmd_if.cmd_duty  = '0;

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_pwm", int'(servo_pwm), 0);
    checkOutput("rst_tick", int'(frame_tick), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_ready", int'(cmd_if.cmd_ready), 0);

    // Release: neutral 40-cycle pulses in 80-cycle frames.
    reset_n = 1'b1;
    #1;
    checkOutput("ready_after_release", int'(cmd_if.cmd_ready), 1);
    pushExp(40, 40, 0);
    waitTick(n);
    checkOutput("first_frame_len", n, 80);
    pushExp(40, 40, 0);
    waitTick(n);
    checkOutput("second_frame_len", n, 80);

`ifndef SERVO_NEUTRAL_TIMEOUT_EN
    $display("[TB] ramp ch0 to 16");
    pushExp(40, 40, 1);
    applyStimulus(0, 16, w);
    checkOutput("t2_busy_after_cmd", int'(busy), 1);
    waitTick(n);
    expectFrame(48, 40, 1);
    expectFrame(56, 40, 0);
    expectFrame(64, 40, 0);
    expectFrame(64, 40, 0);

    $display("[TB] ch1 clamps and out-of-range channel");
    pushExp(64, 40, 1);
    applyStimulus(1, 25, w);
    checkOutput("t3_busy_after_cmd", int'(busy), 1);
    applyStimulus(1, 0, w);
    applyStimulus(3, 9, w);
    checkOutput("t3_ch3_accept_wait", w, 0);
    waitTick(n);
    expectFrame(64, 32, 1);
    expectFrame(64, 24, 1);
    expectFrame(64, 16, 0);
    expectFrame(64, 8, 0);

    $display("[TB] command presented on frame end");
    pushExp(64, 8, 0);
    repeat (79) @(posedge clk);
    #1;
    checkOutput("t4_ready_on_fe", int'(cmd_if.cmd_ready), 0);
    checkOutput("t4_tick_before_fe_edge", int'(frame_tick), 0);
    applyStimulus(0, 19, w);
    checkOutput("t4_refused_cycles", w, 1);
    checkOutput("t4_busy_after_cmd", int'(busy), 1);
    expectFrame(64, 8, 0);
    expectFrame(72, 8, 0);

    $display("[TB] enable low mid-pulse, then reset mid-ramp");
    pushExp(72, 8, 1);
    applyStimulus(0, 2, w);
    waitTick(n);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("t5_pwm_mid_pulse", int'(servo_pwm), 1);
    enable = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("t5_pwm_after_disable", int'(servo_pwm), 0);
    checkOutput("t5_ready_while_disabled", int'(cmd_if.cmd_ready), 1);
    repeat (100) @(posedge clk);
    #1;
    checkOutput("t5_pwm_still_low", int'(servo_pwm), 0);
    checkOutput("t5_no_tick_disabled", int'(frame_tick), 0);
    enable = 1'b1;
    pushExp(64, 8, 1);
    waitTick(n);
    checkOutput("t5_frame_len_after_enable", n, 80);
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("t5_rst_pwm", int'(servo_pwm), 0);
    checkOutput("t5_rst_busy", int'(busy), 0);
    checkOutput("t5_rst_ready", int'(cmd_if.cmd_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    pushExp(40, 40, 0);
    waitTick(n);
    checkOutput("t5_frame_len_after_reset", n, 80);
    expectFrame(40, 40, 0);
`else
    $display("[TB] neutral timeout");
    pushExp(40, 40, 1);
    applyStimulus(0, 18, w);
    waitTick(n);
    expectFrame(48, 40, 1);
    expectFrame(56, 40, 1);
    expectFrame(64, 40, 1);
    expectFrame(56, 40, 1);
    expectFrame(48, 40, 0);
    expectFrame(40, 40, 0);

    $display("[TB] timeout restart by a new command");
    pushExp(40, 40, 1);
    applyStimulus(1, 18, w);
    waitTick(n);
    expectFrame(40, 48, 1);
    pushExp(40, 56, 1);
    applyStimulus(1, 18, w);
    waitTick(n);
    expectFrame(40, 64, 0);
    expectFrame(40, 72, 1);
    expectFrame(40, 72, 1);
    expectFrame(40, 64, 1);
    expectFrame(40, 56, 1);
    expectFrame(40, 48, 0);
    expectFrame(40, 40, 0);
`endif

    @(negedge clk);
    @(negedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
